// File: rtl/carp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : carp_pkg
// Description : Shared address width, reset vector and address type for the
//               CARP RISC-V core front end.
// Revision    : 1.0 - initial release
// ============================================================================
package carp_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] addr_t;

  localparam addr_t RESET_VECTOR = 32'h0000_0000;

  // Instruction fetch requires 4-byte alignment.
  function automatic logic is_misaligned(input addr_t addr);
    return |addr[1:0];
  endfunction

endpackage : carp_pkg
`default_nettype wire

// File: rtl/en_dff_ar.sv
`default_nettype none
// ============================================================================
// Module      : en_dff_ar
// Description : Generic load-enabled register with asynchronous active-high
//               reset to a parameterised value.
// Revision    : 1.0 - initial release
// ============================================================================
module en_dff_ar #(
  parameter int              WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule : en_dff_ar
`default_nettype wire

// File: rtl/program_counter.sv
`default_nettype none
// ============================================================================
// Module      : program_counter
// Description : Architectural PC register; loads the next-PC value when
//               enabled, async reset to RESET_VECTOR. Optional macro
//               PC_ALIGN_CHECK_EN adds the pc_misaligned flag output.
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter
  import carp_pkg::*;
#(
  parameter int    XLEN         = carp_pkg::XLEN,
  parameter addr_t RESET_VECTOR = carp_pkg::RESET_VECTOR
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  pc_en,
  input  addr_t pc_in,
`ifdef PC_ALIGN_CHECK_EN
  output logic  pc_misaligned,
`endif
  output addr_t pc_out
);

  addr_t w_pc_q;

  en_dff_ar #(
    .WIDTH   (XLEN),
    .RST_VAL (RESET_VECTOR)
  ) u_pc_reg (
    .clk (clk),
    .rst (rst),
    .en  (pc_en),
    .d   (pc_in),
    .q   (w_pc_q)
  );

  assign pc_out = w_pc_q;

`ifdef PC_ALIGN_CHECK_EN
  // Derived from the flop output so it tracks pc_out in the same cycle.
  assign pc_misaligned = is_misaligned(w_pc_q);
`endif

endmodule : program_counter
`default_nettype wire

// File: tb/tb_program_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_counter
// Description : Self-checking bench for program_counter: vector table,
//               hand-written async-reset sequences and randomized traffic
//               against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_counter;

  localparam logic [31:0] C_RESET_VECTOR = 32'h0000_0000;
  localparam int          C_NUM_VECS     = 12;
  localparam int          C_NUM_RAND     = 300;

  logic        clk;
  logic        rst;
  logic        pc_en;
  logic [31:0] pc_in;
  logic [31:0] pc_out;
`ifdef PC_ALIGN_CHECK_EN
  logic        pc_misaligned;
`endif

  int total;
  int bad;

  typedef struct packed {
    logic        rst;
    logic        en;
    logic [31:0] pc_in;
    logic [31:0] exp_pc;
    logic        exp_mis;
  } vec_t;

  vec_t vecs [C_NUM_VECS];

  program_counter dut (
    .clk           (clk),
    .rst           (rst),
    .pc_en         (pc_en),
    .pc_in         (pc_in),
`ifdef PC_ALIGN_CHECK_EN
    .pc_misaligned (pc_misaligned),
`endif
    .pc_out        (pc_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_pc(input string name, input logic [31:0] exp_pc, input logic exp_mis);
    check(name, pc_out, exp_pc);
`ifdef PC_ALIGN_CHECK_EN
    check({name, "_mis"}, {31'b0, pc_misaligned}, {31'b0, exp_mis});
`else
    if (exp_mis === 1'bx) $display("note: unexpected X flag");
`endif
  endtask

  // Drive at the falling edge, sample 1 time unit after the next rising edge.
  task automatic apply(input logic r, input logic e, input logic [31:0] d);
    @(negedge clk);
    rst   = r;
    pc_en = e;
    pc_in = d;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] model_pc;

  initial begin
    total = 0;
    bad   = 0;

    vecs[0]  = '{rst: 1'b1, en: 1'b1, pc_in: 32'h0000_0001, exp_pc: 32'h0000_0000, exp_mis: 1'b0};
    vecs[1]  = '{rst: 1'b0, en: 1'b1, pc_in: 32'h0000_feed, exp_pc: 32'h0000_feed, exp_mis: 1'b1};
    vecs[2]  = '{rst: 1'b0, en: 1'b0, pc_in: 32'h0000_beef, exp_pc: 32'h0000_feed, exp_mis: 1'b1};
    vecs[3]  = '{rst: 1'b0, en: 1'b0, pc_in: 32'h0000_beef, exp_pc: 32'h0000_feed, exp_mis: 1'b1};
    vecs[4]  = '{rst: 1'b0, en: 1'b0, pc_in: 32'h0000_beef, exp_pc: 32'h0000_feed, exp_mis: 1'b1};
    vecs[5]  = '{rst: 1'b0, en: 1'b1, pc_in: 32'h0000_beef, exp_pc: 32'h0000_beef, exp_mis: 1'b1};
    vecs[6]  = '{rst: 1'b0, en: 1'b1, pc_in: 32'h0000_dead, exp_pc: 32'h0000_dead, exp_mis: 1'b1};
    vecs[7]  = '{rst: 1'b0, en: 1'b1, pc_in: 32'h0000_abba, exp_pc: 32'h0000_abba, exp_mis: 1'b1};
    vecs[8]  = '{rst: 1'b0, en: 1'b1, pc_in: 32'h0000_beed, exp_pc: 32'h0000_beed, exp_mis: 1'b1};
    vecs[9]  = '{rst: 1'b0, en: 1'b1, pc_in: 32'h0000_abb8, exp_pc: 32'h0000_abb8, exp_mis: 1'b0};
    vecs[10] = '{rst: 1'b0, en: 1'b1, pc_in: 32'hffff_ffff, exp_pc: 32'hffff_ffff, exp_mis: 1'b1};
    vecs[11] = '{rst: 1'b0, en: 1'b0, pc_in: 32'h0000_0000, exp_pc: 32'hffff_ffff, exp_mis: 1'b1};

    // Async reset must take effect before the first clock edge.
    rst   = 1'b1;
    pc_en = 1'b0;
    pc_in = 32'h0;
    #1;
    check_pc("reset_async", C_RESET_VECTOR, 1'b0);

    for (int i = 0; i < C_NUM_VECS; i++) begin
      apply(vecs[i].rst, vecs[i].en, vecs[i].pc_in);
      check_pc($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_mis);
    end

    // Mid-cycle clear: load a value, then assert rst between edges.
    apply(1'b0, 1'b1, 32'h0000_feed);
    check_pc("pre_clear", 32'h0000_feed, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_pc("mid_clear", C_RESET_VECTOR, 1'b0);
    apply(1'b1, 1'b1, 32'h1234_5677);
    check_pc("clear_held", C_RESET_VECTOR, 1'b0);
    // First edge after release loads.
    apply(1'b0, 1'b1, 32'h1234_5677);
    check_pc("first_load", 32'h1234_5677, 1'b1);

    // Randomized traffic against the architectural model.
    model_pc = 32'h1234_5677;
    for (int n = 0; n < C_NUM_RAND; n++) begin
      logic        r;
      logic        e;
      logic [31:0] d;
      r = ($urandom_range(0, 15) == 0);
      e = $urandom_range(0, 1) == 1;
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d[1:0] = 2'b00;
      apply(r, e, d);
      if (r)      model_pc = C_RESET_VECTOR;
      else if (e) model_pc = d;
      check_pc("random", model_pc, |model_pc[1:0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_program_counter
`default_nettype wire
